lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
- Receive-side PRBS checker for the parallel XNOR Fibonacci LFSR stream produced by the team's LFSR generator. One word is presented per data-valid cycle.
- Self-seeds from the incoming data, predicts each next word and declares lock after a run of correct predictions.
- While locked, it flywheels on its own prediction and counts mismatching words.
- Sits at the far end of a link or datapath under test (display framebuffer path, loopback) to measure integrity.

Parameters:
- NUM_BITS, 4, LFSR width; legal 3..16, any other value is an elaboration error.
- LOCK_COUNT, 4, consecutive correct predictions needed to lock (>=1).
- UNLOCK_COUNT, 3, consecutive mismatches while locked that drop lock (>=1).
- CNT_WIDTH, 16, error counter width.

Ports:
- i_Clk  in  1  clock.
- i_Rst  in  1  synchronous active-high reset.
- i_Data_DV  in  1  i_Data valid this cycle.
- i_Data  in  NUM_BITS  received LFSR word.
- i_Clear_Count  in  1  clears o_Error_Count.
- o_Locked  out  1  checker is in LOCKED state.
- o_Error  out  1  one-cycle pulse per mismatching word while locked.
- o_Error_Count  out  CNT_WIDTH  saturating count of mismatches while locked.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset state: SEARCH, have_prev=0, match_cnt=0, miss_cnt=0, o_Locked=0, o_Error=0, o_Error_Count=0. Reset mid-operation discards lock and count on the next edge.
- Bits are numbered 1..NUM_BITS (LSB=1).
- Next-word function: next(w) = {w[NUM_BITS-1:1], fb}, where fb = NOT(XOR of tapped bits of w).
- Taps per NUM_BITS:
  3:3,2  4:4,3  5:5,3  6:6,5  7:7,6  8:8,6,5,4  9:9,5  10:10,7  11:11,9  12:12,6,4,1  13:13,4,3,1  14:14,5,3,1  15:15,14  16:16,15,13,4
- All-ones is the XNOR lockup word. A received all-ones word is always a mismatch.
- Match condition on a DV cycle: have_prev=1 AND i_Data==next(prev) AND i_Data != all-ones.
- Cycles without i_Data_DV: all state holds; o_Error=0.
- SEARCH state (self-seeding):
  - Every DV cycle: prev<=i_Data, have_prev<=1.
  - On match: match_cnt++. When it reaches LOCK_COUNT: go to LOCKED, miss_cnt<=0.
  - On mismatch: match_cnt<=0.
  - Mismatches in SEARCH never pulse o_Error and never count.
- LOCKED state (flywheel):
  - Every DV cycle: prev<=next(prev), regardless of i_Data, so a single corrupt word yields exactly one error.
  - On match: miss_cnt<=0.
  - On mismatch: o_Error=1 for one cycle; o_Error_Count increments, saturating at all-ones; miss_cnt++.
  - When miss_cnt reaches UNLOCK_COUNT: go to SEARCH, match_cnt<=0, prev<=i_Data (reseed from the data).
  - The final unlocking mismatch is still counted and pulsed.
- Latency: o_Locked, o_Error and o_Error_Count are registered and update on the edge that samples the DV word (visible the following cycle).
- i_Clear_Count:
  - Sets the count to 0 next cycle and does not affect lock.
  - If asserted together with an increment, clear wins (result 0).
- Wrap-around: the sequence's natural period of 2^NUM_BITS-1 words needs no special handling; wrap from the last word back to the seed word is an ordinary match.

Test Plan:
1. NUM_BITS=4, LOCK_COUNT=4: after reset, drive DV words 0x0,0x1,0x3,0x7,0xE -> o_Locked rises the cycle after 0xE; o_Error never pulses; count=0.
2. Locked, continue 0xD,0xB,0x6 and run 35 more words with 2-cycle DV gaps -> no errors; o_Locked stays 1 across gaps and across the sequence period.
3. Locked, replace the word 0xB with 0x3, then resume the correct sequence -> exactly one o_Error pulse; count=1; lock held.
4. Locked, UNLOCK_COUNT=3: inject 3 consecutive wrong words -> 3 pulses, count=3, o_Locked falls after the 3rd. A slipped but correct sequence then relocks after 4 matches.
5. Locked: present 0xF once -> counted as an error. While in SEARCH, repeated 0xF -> never locks and never counts.
6. CNT_WIDTH=2 with 5 mismatches -> count saturates at 3. Then assert i_Clear_Count on the same cycle as a mismatch -> count=0. Assert i_Rst while locked -> all outputs 0 next cycle.

Source files
------------

// File: rtl/lfsr_checker.sv
// Receive-side checker for the XNOR Fibonacci LFSR stream: self-seeds, locks after a run of
// correct predictions, then flywheels and counts mismatching words.
module lfsr_checker #(
   parameter int unsigned NUM_BITS     = 4,
   parameter int unsigned LOCK_COUNT   = 4,
   parameter int unsigned UNLOCK_COUNT = 3,
   parameter int unsigned CNT_WIDTH    = 16
) (
   input  logic                 i_Clk,
   input  logic                 i_Rst,
   input  logic                 i_Data_DV,
   input  logic [NUM_BITS-1:0]  i_Data,
   input  logic                 i_Clear_Count,
   output logic                 o_Locked,
   output logic                 o_Error,
   output logic [CNT_WIDTH-1:0] o_Error_Count
);

   if (NUM_BITS < 3 || NUM_BITS > 16) begin : gen_bad_width
      $error("lfsr_checker: NUM_BITS must be in 3..16");
   end
   if (LOCK_COUNT < 1 || UNLOCK_COUNT < 1) begin : gen_bad_count
      $error("lfsr_checker: LOCK_COUNT and UNLOCK_COUNT must be >= 1");
   end

   // Tap masks in 0-based bit positions (tap t sits at bit t-1).
   function automatic logic [15:0] tap_mask(int unsigned n);
      case (n)
         3:       return 16'h0006;
         4:       return 16'h000C;
         5:       return 16'h0014;
         6:       return 16'h0030;
         7:       return 16'h0060;
         8:       return 16'h00B8;
         9:       return 16'h0110;
         10:      return 16'h0240;
         11:      return 16'h0500;
         12:      return 16'h0829;
         13:      return 16'h100D;
         14:      return 16'h2015;
         15:      return 16'h6000;
         16:      return 16'hD008;
         default: return 16'h0000;
      endcase
   endfunction

   localparam logic [15:0] TapMaskFull = tap_mask(NUM_BITS);
   localparam int unsigned MatchW      = $clog2(LOCK_COUNT + 1);
   localparam int unsigned MissW       = $clog2(UNLOCK_COUNT + 1);

   typedef enum logic {StSearch, StLocked} state_e;

   state_e                 state_q;
   logic [NUM_BITS-1:0]    prev_q;
   logic                   have_prev_q;
   logic [MatchW-1:0]      match_cnt_q;
   logic [MissW-1:0]       miss_cnt_q;
   logic                   error_q;
   logic [CNT_WIDTH-1:0]   err_cnt_q;

   logic [NUM_BITS-1:0]    pred;
   logic                   is_match;
   logic                   last_miss;

   always_comb begin
      pred      = {prev_q[NUM_BITS-2:0], ~^(prev_q & TapMaskFull[NUM_BITS-1:0])};
      // All-ones is the XNOR lockup word and can never be a valid match.
      is_match  = have_prev_q && (i_Data == pred) && (i_Data != '1);
      last_miss = (miss_cnt_q == MissW'(UNLOCK_COUNT - 1));
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q     <= StSearch;
         prev_q      <= '0;
         have_prev_q <= 1'b0;
         match_cnt_q <= '0;
         miss_cnt_q  <= '0;
         error_q     <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         error_q <= 1'b0;
         if (i_Data_DV) begin
            case (state_q)
               StSearch: begin
                  prev_q      <= i_Data;
                  have_prev_q <= 1'b1;
                  if (!is_match) begin
                     match_cnt_q <= '0;
                  end else if (match_cnt_q == MatchW'(LOCK_COUNT - 1)) begin
                     state_q     <= StLocked;
                     match_cnt_q <= '0;
                     miss_cnt_q  <= '0;
                  end else begin
                     match_cnt_q <= match_cnt_q + 1'b1;
                  end
               end
               StLocked: begin
                  if (is_match) begin
                     prev_q     <= pred;
                     miss_cnt_q <= '0;
                  end else begin
                     error_q <= 1'b1;
                     if (err_cnt_q != '1) begin
                        err_cnt_q <= err_cnt_q + 1'b1;
                     end
                     if (last_miss) begin
                        state_q     <= StSearch;
                        match_cnt_q <= '0;
                        miss_cnt_q  <= '0;
                        prev_q      <= i_Data;
                     end else begin
                        prev_q     <= pred;
                        miss_cnt_q <= miss_cnt_q + 1'b1;
                     end
                  end
               end
               default: state_q <= StSearch;
            endcase
         end
         // Clear overrides any same-cycle increment.
         if (i_Clear_Count) begin
            err_cnt_q <= '0;
         end
      end
   end

   assign o_Locked      = (state_q == StLocked);
   assign o_Error       = error_q;
   assign o_Error_Count = err_cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: directed vector table plus random traffic against a reference model.
module tb_lfsr_checker;

   localparam int LockN   = 4;
   localparam int UnlockN = 3;

   logic        clk = 1'b0;
   logic        rst, dv, clr;
   logic [3:0]  data;
   logic        lock_a, err_a, lock_b, err_b;
   logic [15:0] cnt_a;
   logic [1:0]  cnt_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lfsr_checker #(.NUM_BITS(4), .LOCK_COUNT(LockN), .UNLOCK_COUNT(UnlockN), .CNT_WIDTH(16))
   dut_a (
      .i_Clk(clk), .i_Rst(rst), .i_Data_DV(dv), .i_Data(data), .i_Clear_Count(clr),
      .o_Locked(lock_a), .o_Error(err_a), .o_Error_Count(cnt_a)
   );

   lfsr_checker #(.NUM_BITS(4), .LOCK_COUNT(LockN), .UNLOCK_COUNT(UnlockN), .CNT_WIDTH(2))
   dut_b (
      .i_Clk(clk), .i_Rst(rst), .i_Data_DV(dv), .i_Data(data), .i_Clear_Count(clr),
      .o_Locked(lock_b), .o_Error(err_b), .o_Error_Count(cnt_b)
   );

   typedef struct {
      bit rst;
      bit dv;
      int data;
      bit clr;
      bit e_lock;
      bit e_err;
      int e_cnt;
      int e_cnt2;
   } vec_t;

   vec_t tbl[$];
   int   seq[15] = '{0, 1, 3, 7, 14, 13, 11, 6, 12, 9, 2, 5, 10, 4, 8};

   // Reference next-word: shift left, feed back XNOR of taps 4 and 3.
   function automatic int lfsr_next(int w);
      int taps[2] = '{4, 3};
      int fb = 1;
      foreach (taps[i]) fb = fb ^ ((w >> (taps[i] - 1)) & 1);
      return ((w << 1) | fb) & 15;
   endfunction

   function automatic void check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   function automatic void add(bit r, bit v, int d, bit c, bit el, bit ee, int ec, int ec2);
      vec_t e;
      e.rst = r; e.dv = v; e.data = d; e.clr = c;
      e.e_lock = el; e.e_err = ee; e.e_cnt = ec; e.e_cnt2 = ec2;
      tbl.push_back(e);
   endfunction

   function automatic void build_table();
      int p;
      int q;
      add(1, 0, 0, 0, 0, 0, 0, 0);
      add(1, 1, 5, 0, 0, 0, 0, 0);
      // Seed plus four matches -> lock.
      for (int k = 0; k < 4; k++) add(0, 1, seq[k], 0, 0, 0, 0, 0);
      add(0, 1, seq[4], 0, 1, 0, 0, 0);
      p = 5;
      for (int k = 0; k < 3; k++) begin add(0, 1, seq[p % 15], 0, 1, 0, 0, 0); p++; end
      // Gapped run across more than two sequence periods; idle data is garbage.
      for (int k = 0; k < 35; k++) begin
         add(0, 0, 15, 0, 1, 0, 0, 0);
         add(0, 0, 15, 0, 1, 0, 0, 0);
         add(0, 1, seq[p % 15], 0, 1, 0, 0, 0);
         p++;
      end
      while (p % 15 != 6) begin add(0, 1, seq[p % 15], 0, 1, 0, 0, 0); p++; end
      // Single corrupt word (0xB replaced by 0x3).
      add(0, 1, 3, 0, 1, 1, 1, 1); p++;
      for (int k = 0; k < 3; k++) begin add(0, 1, seq[p % 15], 0, 1, 0, 1, 1); p++; end
      // Slipped stream: three misses drop lock, then four matches relock.
      add(0, 1, seq[(p + 5) % 15], 0, 1, 1, 2, 2); p++;
      add(0, 1, seq[(p + 5) % 15], 0, 1, 1, 3, 3); p++;
      add(0, 1, seq[(p + 5) % 15], 0, 0, 1, 4, 3); p++;
      for (int k = 0; k < 4; k++) begin
         add(0, 1, seq[(p + 5) % 15], 0, k == 3, 0, 4, 3); p++;
      end
      q = p + 5;
      add(0, 1, 15, 0, 1, 1, 5, 3); q++;
      add(0, 1, seq[q % 15], 0, 1, 0, 5, 3); q++;
      add(0, 1, seq[q % 15], 0, 1, 0, 5, 3); q++;
      add(0, 1, 15, 0, 1, 1, 6, 3);
      add(0, 1, 15, 0, 1, 1, 7, 3);
      add(0, 1, 15, 0, 0, 1, 8, 3);
      for (int k = 0; k < 6; k++) add(0, 1, 15, 0, 0, 0, 8, 3);
      for (int k = 0; k < 4; k++) add(0, 1, seq[k], 0, 0, 0, 8, 3);
      add(0, 1, seq[4], 0, 1, 0, 8, 3);
      // Clear together with a mismatch: clear wins.
      add(0, 1, 0, 1, 1, 1, 0, 0);
      add(0, 1, seq[6], 0, 1, 0, 0, 0);
      add(0, 1, 0, 0, 1, 1, 1, 1);
      add(0, 0, 0, 1, 1, 0, 0, 0);
      add(1, 1, seq[8], 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   // Reference model state.
   bit m_locked, m_have, m_err;
   int m_prev, m_match, m_miss, m_cnt;

   function automatic void model_step(bit r, bit v, int d, bit c);
      bit hit;
      if (r) begin
         m_locked = 0; m_have = 0; m_err = 0;
         m_prev = 0; m_match = 0; m_miss = 0; m_cnt = 0;
         return;
      end
      m_err = 0;
      if (v) begin
         hit = m_have && (d == lfsr_next(m_prev)) && (d != 15);
         if (!m_locked) begin
            m_prev = d;
            m_have = 1;
            if (hit) begin
               m_match++;
               if (m_match >= LockN) begin m_locked = 1; m_match = 0; m_miss = 0; end
            end else begin
               m_match = 0;
            end
         end else begin
            m_prev = lfsr_next(m_prev);
            if (hit) begin
               m_miss = 0;
            end else begin
               m_err = 1;
               m_cnt++;
               m_miss++;
               if (m_miss >= UnlockN) begin m_locked = 0; m_match = 0; m_prev = d; end
            end
         end
      end
      if (c) m_cnt = 0;
   endfunction

   function automatic int min_int(int a, int b);
      return (a < b) ? a : b;
   endfunction

   task automatic apply(bit r, bit v, int d, bit c);
      rst  = r;
      dv   = v;
      data = 4'(d);
      clr  = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int tx, burst, d;
      bit r, v, c;
      rst = 1'b1; dv = 1'b0; data = '0; clr = 1'b0;
      build_table();
      foreach (tbl[i]) begin
         apply(tbl[i].rst, tbl[i].dv, tbl[i].data, tbl[i].clr);
         check($sformatf("tbl[%0d].locked", i), int'(lock_a), int'(tbl[i].e_lock));
         check($sformatf("tbl[%0d].error", i), int'(err_a), int'(tbl[i].e_err));
         check($sformatf("tbl[%0d].count", i), int'(cnt_a), tbl[i].e_cnt);
         check($sformatf("tbl[%0d].count_w2", i), int'(cnt_b), tbl[i].e_cnt2);
      end

      model_step(1, 0, 0, 0);
      apply(1, 0, 0, 0);
      tx    = $urandom_range(0, 14);
      burst = 0;
      for (int n = 0; n < 2500; n++) begin
         r = ($urandom_range(0, 399) == 0);
         v = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 49) == 0);
         d = $urandom_range(0, 15);
         if (v) begin
            if (burst > 0) begin
               burst--;
               if ($urandom_range(0, 3) == 0) d = 15;
            end else if ($urandom_range(0, 99) < 6) begin
               burst = $urandom_range(0, 4);
            end else if ($urandom_range(0, 99) < 2) begin
               tx = $urandom_range(0, 14);
               d  = tx;
            end else begin
               d = tx;
            end
            tx = lfsr_next(tx);
         end
         model_step(r, v, d, c);
         apply(r, v, d, c);
         check($sformatf("rnd[%0d].locked", n), int'(lock_a), int'(m_locked));
         check($sformatf("rnd[%0d].error", n), int'(err_a), int'(m_err));
         check($sformatf("rnd[%0d].count", n), int'(cnt_a), min_int(m_cnt, 65535));
         check($sformatf("rnd[%0d].count_w2", n), int'(cnt_b), min_int(m_cnt, 3));
         check($sformatf("rnd[%0d].locked_w2", n), int'(lock_b), int'(m_locked));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
